// File: rtl/mult_share_ctrl_if.sv
// mult_share_ctrl_if: request/response channels of the two requesters sharing the multiplier.
// The master side belongs to the requesters, and the slave side belongs to the controller.
interface mult_share_ctrl_if;
    logic        req0_valid;
    logic [7:0]  req0_x;
    logic [7:0]  req0_y;
    logic        req0_ready;
    logic        rsp0_valid;
    logic [15:0] rsp0_p;
    logic        rsp0_ready;

    logic        req1_valid;
    logic [7:0]  req1_x;
    logic [7:0]  req1_y;
    logic        req1_ready;
    logic        rsp1_valid;
    logic [15:0] rsp1_p;
    logic        rsp1_ready;

    modport master (
        output req0_valid, req0_x, req0_y, rsp0_ready,
        output req1_valid, req1_x, req1_y, rsp1_ready,
        input  req0_ready, rsp0_valid, rsp0_p,
        input  req1_ready, rsp1_valid, rsp1_p
    );

    modport slave (
        input  req0_valid, req0_x, req0_y, rsp0_ready,
        input  req1_valid, req1_x, req1_y, rsp1_ready,
        output req0_ready, rsp0_valid, rsp0_p,
        output req1_ready, rsp1_valid, rsp1_p
    );
endinterface

// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: shares one combinational 8x8 multiplier between two requesters.
// The controller registers the granted operands and holds them for SETTLE cycles.
// It then captures the product and returns it to the owner over a valid/ready channel.
// Optional feature: define MULT_SHARE_RR_EN for round-robin arbitration.
// When it is undefined, arbitration is fixed priority with requester 0 first.
module mult_share_ctrl #(
    parameter int unsigned SETTLE = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    mult_share_ctrl_if.slave        bus,
    output logic [7:0]              mul_x,
    output logic [7:0]              mul_y,
    input  logic [15:0]             mul_p,
    input  logic                    mul_cout,
    output logic                    busy,
    output logic                    err
);

    typedef enum logic [1:0] {StIdle, StSettle, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;
    logic [7:0]  mul_x_q, mul_x_d;
    logic [7:0]  mul_y_q, mul_y_d;
    logic        rsp0_valid_q, rsp0_valid_d;
    logic        rsp1_valid_q, rsp1_valid_d;
    logic [15:0] rsp0_p_q, rsp0_p_d;
    logic [15:0] rsp1_p_q, rsp1_p_d;
    logic        err_q, err_d;
    logic        grant1, acc0, acc1, rsp_hs;

`ifdef MULT_SHARE_RR_EN
    logic last_q, last_d;

    // Round-robin arbitration: on contention, grant the requester that was not served last.
    always_comb begin
        if (bus.req0_valid && bus.req1_valid) begin
            grant1 = ~last_q;
        end else begin
            grant1 = bus.req1_valid;
        end
    end

    // Last-served pointer: it updates on each accept and resets to "1" so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Fixed priority: requester 1 is granted only when requester 0 is not asking.
    always_comb begin
        grant1 = bus.req1_valid & ~bus.req0_valid;
    end
`endif

    // Accepts happen only in idle and never while reset is asserted.
    always_comb begin
        acc0   = (state_q == StIdle) && !rst && bus.req0_valid && !grant1;
        acc1   = (state_q == StIdle) && !rst && bus.req1_valid && grant1;
        rsp_hs = owner_q ? bus.rsp1_ready : bus.rsp0_ready;
    end

    // Next-state logic: accept, settle countdown with capture, and response hand-off.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        mul_x_d      = mul_x_q;
        mul_y_d      = mul_y_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp1_valid_d = rsp1_valid_q;
        rsp0_p_d     = rsp0_p_q;
        rsp1_p_d     = rsp1_p_q;
        err_d        = err_q;
`ifdef MULT_SHARE_RR_EN
        last_d       = last_q;
`endif
        case (state_q)
            StIdle: begin
                if (acc0 || acc1) begin
                    mul_x_d = acc1 ? bus.req1_x : bus.req0_x;
                    mul_y_d = acc1 ? bus.req1_y : bus.req0_y;
                    owner_d = acc1;
                    cnt_d   = 4'(SETTLE - 1);
                    state_d = StSettle;
`ifdef MULT_SHARE_RR_EN
                    last_d  = acc1;
`endif
                end
            end
            StSettle: begin
                if (cnt_q == 4'd0) begin
                    // The carry-out goes only to err and is never merged into the product.
                    if (owner_q) begin
                        rsp1_valid_d = 1'b1;
                        rsp1_p_d     = mul_p;
                    end else begin
                        rsp0_valid_d = 1'b1;
                        rsp0_p_d     = mul_p;
                    end
                    err_d   = err_q | mul_cout;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                // Clearing both products keeps the response channel that is not in use at zero.
                if (rsp_hs) begin
                    rsp0_valid_d = 1'b0;
                    rsp1_valid_d = 1'b0;
                    rsp0_p_d     = 16'd0;
                    rsp1_p_d     = 16'd0;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers, with a synchronous reset that aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            owner_q      <= 1'b0;
            mul_x_q      <= 8'd0;
            mul_y_q      <= 8'd0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_p_q     <= 16'd0;
            rsp1_p_q     <= 16'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            mul_x_q      <= mul_x_d;
            mul_y_q      <= mul_y_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_p_q     <= rsp0_p_d;
            rsp1_p_q     <= rsp1_p_d;
            err_q        <= err_d;
        end
    end

    assign bus.req0_ready = acc0;
    assign bus.req1_ready = acc1;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp0_p     = rsp0_p_q;
    assign bus.rsp1_p     = rsp1_p_q;
    assign mul_x          = mul_x_q;
    assign mul_y          = mul_y_q;
    assign busy           = (state_q != StIdle);
    assign err            = err_q;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// tb_mult_share_ctrl: directed scenarios followed by randomized traffic.
// A transaction-level model checks every cycle of the run.
module tb_mult_share_ctrl;
    localparam int SETTLE = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  mul_x, mul_y;
    logic [15:0] mul_p;
    logic        mul_cout;
    logic        busy, err;
    logic        force_cout = 1'b0;

    mult_share_ctrl_if bus ();

    mult_share_ctrl #(.SETTLE(SETTLE)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .mul_x    (mul_x),
        .mul_y    (mul_y),
        .mul_p    (mul_p),
        .mul_cout (mul_cout),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    // This is an ideal multiplier. The bench can force its carry-out.
    assign mul_p    = 16'(mul_x) * 16'(mul_y);
    assign mul_cout = force_cout;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(busy), 0);
        @(posedge clk);
        #1;
    endtask

    // Transaction-level reference: one pending op has an owner, a product and an accept cycle.
    int          cyc = 0;
    logic        model_ok = 1'b0;
    logic        pend = 1'b0;
    logic        pown = 1'b0;
    logic [15:0] pprod = 16'd0;
    int          pacc = 0;
    logic [7:0]  emx = 8'd0, emy = 8'd0;
    logic        eerr = 1'b0;
    logic        elast = 1'b1;
    int          acc_own[$];
    int          acc_cyc[$];
    int          rsp_prod[$];
    int          rsp_seen = 0;

    always @(negedge clk) begin
        logic g1, er0, er1, rv, v0, v1;
        cyc++;
        v0 = bus.req0_valid;
        v1 = bus.req1_valid;
        if (v0 && bus.req0_ready) begin acc_own.push_back(0); acc_cyc.push_back(cyc); end
        if (v1 && bus.req1_ready) begin acc_own.push_back(1); acc_cyc.push_back(cyc); end
        if (bus.rsp0_valid || bus.rsp1_valid) rsp_seen++;
        if (bus.rsp0_valid && bus.rsp0_ready) rsp_prod.push_back(int'(bus.rsp0_p));
        if (bus.rsp1_valid && bus.rsp1_ready) rsp_prod.push_back(int'(bus.rsp1_p));

`ifdef MULT_SHARE_RR_EN
        g1 = (v0 && v1) ? !elast : v1;
`else
        g1 = v1 && !v0;
`endif
        er0 = !pend && !rst && v0 && !g1;
        er1 = !pend && !rst && v1 && g1;
        rv  = pend && (cyc >= pacc + 1 + SETTLE);

        if (model_ok) begin
            check("m_rdy0", 32'(bus.req0_ready), 32'(er0));
            check("m_rdy1", 32'(bus.req1_ready), 32'(er1));
            check("m_vld0", 32'(bus.rsp0_valid), 32'(rv && !pown));
            check("m_vld1", 32'(bus.rsp1_valid), 32'(rv && pown));
            check("m_p0", 32'(bus.rsp0_p), (rv && !pown) ? 32'(pprod) : 0);
            check("m_p1", 32'(bus.rsp1_p), (rv && pown) ? 32'(pprod) : 0);
            check("m_busy", 32'(busy), 32'(pend));
            check("m_mulx", 32'(mul_x), 32'(emx));
            check("m_muly", 32'(mul_y), 32'(emy));
            check("m_err", 32'(err), 32'(eerr));
        end

        if (rst) begin
            model_ok = 1'b1;
            pend     = 1'b0;
            emx      = 8'd0;
            emy      = 8'd0;
            eerr     = 1'b0;
            elast    = 1'b1;
        end else if (model_ok) begin
            if (pend && cyc == pacc + SETTLE && force_cout) eerr = 1'b1;
            if (rv && (pown ? bus.rsp1_ready : bus.rsp0_ready)) begin
                pend = 1'b0;
            end else if (er0 || er1) begin
                pend  = 1'b1;
                pown  = er1;
                emx   = er1 ? bus.req1_x : bus.req0_x;
                emy   = er1 ? bus.req1_y : bus.req0_y;
                pprod = 16'(emx) * 16'(emy);
                pacc  = cyc;
                elast = er1;
            end
        end
    end

    initial begin
        int lat;
        logic seen;
        bus.req0_valid = 0; bus.req0_x = 0; bus.req0_y = 0; bus.rsp0_ready = 0;
        bus.req1_valid = 0; bus.req1_x = 0; bus.req1_y = 0; bus.rsp1_ready = 0;
        do_reset();
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        check("rst_mulx", 32'(mul_x), 0);
        @(posedge clk); #1;

        // Single op: 0xFF*0xFF; the response appears SETTLE+1 cycles after the accept.
        bus.req0_valid = 1; bus.req0_x = 8'hFF; bus.req0_y = 8'hFF;
        tick();
        bus.req0_valid = 0;
        lat = 0; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (bus.rsp0_valid) seen = 1;
        end
        check("single_lat", lat, SETTLE + 1);
        check("single_p", 32'(bus.rsp0_p), 32'hFE01);
        check("single_err", 32'(err), 0);
        check("single_rsp1", 32'(bus.rsp1_valid), 0);
        @(posedge clk); #1;
        bus.rsp0_ready = 1;
        tick();
        bus.rsp0_ready = 0;

        // Backpressure on requester 1 while requester 0 waits.
        bus.req1_valid = 1; bus.req1_x = 8'd12; bus.req1_y = 8'd13;
        tick();
        bus.req1_valid = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.rsp1_valid) seen = 1;
        end
        check("bp_seen", 32'(seen), 1);
        @(posedge clk); #1;
        bus.req0_valid = 1; bus.req0_x = 8'd2; bus.req0_y = 8'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_vld1", 32'(bus.rsp1_valid), 1);
            check("bp_p1", 32'(bus.rsp1_p), 156);
            check("bp_rdy0", 32'(bus.req0_ready), 0);
            @(posedge clk); #1;
        end
        bus.rsp1_ready = 1;
        @(negedge clk);
        check("bp_rdy0_hs", 32'(bus.req0_ready), 0);
        @(posedge clk); #1;
        bus.rsp1_ready = 0;
        @(negedge clk);
        check("bp_rdy0_after", 32'(bus.req0_ready), 1);
        @(posedge clk); #1;
        bus.req0_valid = 0;
        bus.rsp0_ready = 1;
        wait_idle();

        // Contention, starting from reset.
        bus.rsp0_ready = 0;
        do_reset();
        acc_own.delete(); rsp_prod.delete();
        bus.req0_valid = 1; bus.req0_x = 8'd3; bus.req0_y = 8'd4;
        bus.req1_valid = 1; bus.req1_x = 8'd5; bus.req1_y = 8'd6;
        bus.rsp0_ready = 1; bus.rsp1_ready = 1;
        repeat (5 * (SETTLE + 2)) tick();
        bus.req0_valid = 0; bus.req1_valid = 0;
        wait_idle();
        check("cont_n", 32'(acc_own.size() >= 4), 1);
        for (int i = 0; i < 4; i++) begin
`ifdef MULT_SHARE_RR_EN
            check("cont_own", acc_own[i], i % 2);
            check("cont_p", rsp_prod[i], (i % 2) ? 30 : 12);
`else
            check("cont_own", acc_own[i], 0);
            check("cont_p", rsp_prod[i], 12);
`endif
        end

        // Reset asserted in the second settle cycle aborts the op.
        bus.req0_valid = 1; bus.req0_x = 8'd7; bus.req0_y = 8'd9;
        tick();
        bus.req0_valid = 0;
        rsp_seen = 0;
        tick();
        rst = 1;
        tick();
        rst = 0;
        @(negedge clk);
        check("ab_busy", 32'(busy), 0);
        check("ab_vld0", 32'(bus.rsp0_valid), 0);
        check("ab_mulx", 32'(mul_x), 0);
        check("ab_muly", 32'(mul_y), 0);
        @(posedge clk); #1;
        repeat (10) tick();
        check("ab_norsp", rsp_seen, 0);

        // A forced carry-out sets a sticky err.
        force_cout = 1;
        bus.req1_valid = 1; bus.req1_x = 8'd10; bus.req1_y = 8'd10;
        tick();
        bus.req1_valid = 0;
        wait_idle();
        force_cout = 0;
        check("co_err", 32'(err), 1);
        bus.req0_valid = 1; bus.req0_x = 8'd2; bus.req0_y = 8'd2;
        tick();
        bus.req0_valid = 0;
        wait_idle();
        check("co_sticky", 32'(err), 1);
        do_reset();
        @(negedge clk);
        check("co_clear", 32'(err), 0);
        @(posedge clk); #1;

        // Back-to-back throughput with responses always accepted.
        acc_cyc.delete(); rsp_prod.delete();
        bus.rsp0_ready = 1;
        bus.req0_valid = 1;
        for (int i = 0; i < 4 * (SETTLE + 2); i++) begin
            bus.req0_x = 8'($urandom); bus.req0_y = 8'($urandom);
            tick();
        end
        bus.req0_valid = 0;
        wait_idle();
        check("thr_n", 32'(acc_cyc.size() >= 3), 1);
        for (int i = 1; i < acc_cyc.size(); i++) begin
            check("thr_gap", acc_cyc[i] - acc_cyc[i-1], SETTLE + 2);
        end

        // Randomized traffic, with checking done by the model.
        for (int i = 0; i < 3000; i++) begin
            rst            = ($urandom_range(0, 79) == 0);
            bus.req0_valid = 1'($urandom_range(0, 1));
            bus.req1_valid = 1'($urandom_range(0, 1));
            bus.req0_x     = 8'($urandom); bus.req0_y = 8'($urandom);
            bus.req1_x     = 8'($urandom); bus.req1_y = 8'($urandom);
            bus.rsp0_ready = ($urandom_range(0, 3) != 0);
            bus.rsp1_ready = ($urandom_range(0, 3) != 0);
            force_cout     = ($urandom_range(0, 15) == 0);
            tick();
        end
        rst = 0; force_cout = 0;
        bus.req0_valid = 0; bus.req1_valid = 0;
        bus.rsp0_ready = 1; bus.rsp1_ready = 1;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_share_ctrl.md
# mult_share_ctrl

Sequencing and arbitration controller that shares one combinational 8x8 CSA-tree multiplier (16-bit product plus carry-out) between two requesters. It registers the granted operands, holds them stable on the multiplier inputs for a programmable settle window, and captures the product. It returns the product to the owning requester over a valid/ready response channel. It sits between the requesting datapath blocks and the multiplier instance, which it drives directly.

## Interface
- SETTLE, 2, number of cycles operands are held on the multiplier before the product is captured; legal range 1..15.

- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_x, req0_y  in  8 each  requester 0 operands.
- req0_ready  out  1  controller accepts requester 0 this cycle.
- rsp0_valid  out  1  product for requester 0 is available.
- rsp0_p  out  16  product for requester 0.
- rsp0_ready  in  1  requester 0 consumes the response.
- req1_valid, req1_x, req1_y, req1_ready, rsp1_valid, rsp1_p, rsp1_ready: same as the requester 0 ports, for requester 1.
- mul_x, mul_y  out  8 each  registered operands driven to the multiplier.
- mul_p  in  16  multiplier product.
- mul_cout  in  1  multiplier carry-out.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky flag, set when mul_cout=1 at capture.

## Operation
- FSM states: IDLE, SETTLE_W, RESP.
- **IDLE**
  - At most one reqN_ready is high: the one for the granted requester whose reqN_valid is high.
  - The handshake is reqN_valid & reqN_ready.
  - On the handshake: load mul_x/mul_y from that requester, record the owner, load settle counter = SETTLE-1, and go to SETTLE_W.
- **SETTLE_W**
  - Both ready signals are low.
  - The counter decrements each cycle.
  - When the counter is 0: capture mul_p into the owner's rspN_p, set that rspN_valid, OR mul_cout into err, and go to RESP.
- **RESP**
  - rspN_valid and rspN_p are held stable until rspN_ready=1.
  - On that handshake: clear rspN_valid and go to IDLE.
  - The other requester's rsp signals stay at 0.
- **mul_x/mul_y** retain their values after capture and change only on the next accept.
- **Arbitration**
  - Applies in IDLE when both requesters are valid.
  - The policy is selected by the Configuration macro.
  - A lone valid requester is always granted.
- **Width rules**
  - The product is passed through unmodified, 16 bits, zero-extended semantics.
  - mul_cout is never folded into rspN_p.
- **Reset values**
  - State IDLE; req*_ready 0; rsp*_valid 0; rsp*_p 0; mul_x/mul_y 0; busy 0; err 0.
  - Round-robin pointer "last served = 1".
- **Reset mid-operation**
  - Rst in any state aborts the operation; no response is produced.
  - All outputs return to their reset values at the next edge.
  - Requests presented while rst=1 are not accepted.

## Timing
- Accept handshake sampled at the end of cycle n.
- mul_x/mul_y hold the new operands from cycle n+1.
- rspN_valid is high from cycle n+1+SETTLE.
- If rspN_ready is high in the first valid cycle, rspN_valid is a one-cycle pulse.
- After a response handshake in cycle m, the controller is IDLE and can accept again in cycle m+1.
- Minimum issue interval: SETTLE+2 cycles.
- reqN_ready is combinational from state and reqN_valid.
  - Requesters must not make reqN_valid depend on reqN_ready.
- Response backpressure is unbounded; the controller stalls in RESP indefinitely.

## Configuration
- MULT_SHARE_RR_EN
  - **Defined:** round-robin arbitration. With both requesters valid, grant the requester not served last. The pointer updates on each accept. After reset, requester 0 wins first.
  - **Undefined:** fixed priority; requester 0 always wins when valid. The pointer logic is removed.

## Test plan
- **Single op, SETTLE=2:** req0 x=0xFF, y=0xFF accepted in cycle n.
  - rsp0_valid rises in cycle n+3 with rsp0_p=0xFE01.
  - err stays 0.
  - rsp1_valid stays 0.
- **Backpressure:** req1 x=12, y=13; rsp1_ready held low for 5 cycles.
  - rsp1_p=156 stays stable with rsp1_valid=1 throughout.
  - req0_ready stays 0 until the cycle after rsp1_ready=1.
- **Contention with both valid continuously, operands 3x4 and 5x6:**
  - Macro defined: accepts alternate 0,1,0,1 with products 12, 30.
  - Macro undefined: only requester 0 is served.
- **Reset mid-op:** rst=1 in the second SETTLE_W cycle.
  - Next cycle: busy=0, rsp*_valid=0, mul_x=mul_y=0.
  - No response is ever issued for the aborted op.
- **Carry-out check:** model forces mul_cout=1 at capture.
  - err=1 and stays set through later clean ops until rst.
- **SETTLE=1 throughput:** back-to-back req0 ops with rsp0_ready tied high.
  - Accepts every 3 cycles.
  - Each rsp0_valid is a one-cycle pulse 2 cycles after its accept.
